// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexed scan controller for a common-anode
//                seven-segment display. It drives one shared BCD decoder and
//                uses a frame-synchronous shadow register for display updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [3:0]            bcd_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_tick,
    output logic                  upd_done
);

    localparam int c_cnt_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_idx_w = $clog2(DIGITS);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank   = c_cnt_w'(BLANK_CYC);
    localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  c_one     = DIGITS'(1);

    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [4*DIGITS-1:0] r_disp;
    logic [4*DIGITS-1:0] r_pend;
    logic                r_pend_v;
    logic [3:0]          r_bcd;
    logic [DIGITS-1:0]   r_sel;
    logic                r_tick;
    logic                r_upd;

    logic                w_slot_end;
    logic                w_frame_end;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_idx_w-1:0]  w_idx_nxt;
    logic [4*DIGITS-1:0] w_disp_nxt;
    logic [3:0]          w_bcd_nxt;
    logic                w_blank;
    logic [DIGITS-1:0]   w_sel_nxt;

    always_comb begin
        w_slot_end  = (r_cnt == c_cnt_max);
        w_frame_end = w_slot_end && (r_idx == c_idx_max);
        w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
        if (!w_slot_end)
            w_idx_nxt = r_idx;
        else if (r_idx == c_idx_max)
            w_idx_nxt = '0;
        else
            w_idx_nxt = r_idx + 1'b1;
        w_disp_nxt = (w_frame_end && r_pend_v) ? r_pend : r_disp;
    end

    // Outputs are computed from the next-state values so the registered
    // outputs line up with the counter state they describe.
    always_comb begin
        w_bcd_nxt = 4'h0;
        w_blank   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_nxt == c_idx_w'(i)) begin
                w_bcd_nxt = w_disp_nxt[4*i +: 4];
                w_blank   = lz_en && (i != 0) && ((w_disp_nxt >> (4*i)) == '0);
            end
        end
        if ((w_cnt_nxt < c_blank) || w_blank)
            w_sel_nxt = '1;
        else
            w_sel_nxt = ~(c_one << w_idx_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_disp   <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_bcd    <= 4'h0;
            r_sel    <= '1;
            r_tick   <= 1'b0;
            r_upd    <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_idx  <= w_idx_nxt;
            r_disp <= w_disp_nxt;
            if (load) begin
                r_pend   <= data_in;
                r_pend_v <= 1'b1;
            end else if (w_frame_end) begin
                r_pend_v <= 1'b0;
            end
            r_bcd  <= w_bcd_nxt;
            r_sel  <= w_sel_nxt;
            r_tick <= w_frame_end;
            r_upd  <= w_frame_end && r_pend_v;
        end
    end

    assign bcd_out    = r_bcd;
    assign dig_sel    = r_sel;
    assign frame_tick = r_tick;
    assign upd_done   = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Scoreboard bench for seg_scan_ctrl (DIGITS=4, SCAN_DIV=8,
//                BLANK_CYC=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  bcd_out;
    logic [3:0]  dig_sel;
    logic        frame_tick;
    logic        upd_done;

    seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .lz_en(lz_en),
        .bcd_out(bcd_out), .dig_sel(dig_sel), .frame_tick(frame_tick),
        .upd_done(upd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bcd;
        logic [3:0] sel;
        logic       tick;
        logic       upd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: cycles since release, display, shadow, shadow-valid.
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pv;

    task automatic model_reset();
        m_t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
        sb.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1; load = 1'b0; data_in = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Drive one clock edge and push the expected post-edge outputs.
    task automatic drive(input logic ld, input logic [15:0] d, input logic lz);
        exp_t e;
        int   pos, slot, c;
        logic fw, blank;
        load = ld; data_in = d; lz_en = lz;
        @(posedge clk);
        pos = m_t % 32;
        fw  = (pos == 31);
        e.tick = fw;
        e.upd  = fw && m_pv;
        if (fw && m_pv) m_disp = m_pend;
        if (ld) begin
            m_pend = d; m_pv = 1'b1;
        end else if (fw) begin
            m_pv = 1'b0;
        end
        m_t++;
        pos  = m_t % 32;
        slot = pos / 8;
        c    = pos % 8;
        e.bcd = m_disp[slot*4 +: 4];
        blank = lz && (slot >= 1) && ((m_disp >> (4*slot)) == 16'h0);
        e.sel = (c < 2 || blank) ? 4'hf : ~(4'b0001 << slot);
        sb.push_back(e);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        int   ticks = 0;
        rst = 1'b1; load = 1'b0; data_in = '0; lz_en = 1'b0;
        #1;
        total++;
        if ({bcd_out, dig_sel, frame_tick, upd_done} !== {4'h0, 4'hf, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got bcd=%h sel=%b tick=%b upd=%b want bcd=0 sel=1111 tick=0 upd=0",
                     bcd_out, dig_sel, frame_tick, upd_done);
        end
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 16'h0, 1'b0);
            e = sb.pop_front();
            total++;
            if ({bcd_out, dig_sel, frame_tick, upd_done} !== {e.bcd, e.sel, e.tick, e.upd}) begin
                bad++;
                $display("FAIL scan cyc=%0d got bcd=%h sel=%b tick=%b upd=%b want bcd=%h sel=%b tick=%b upd=%b",
                         i + 1, bcd_out, dig_sel, frame_tick, upd_done, e.bcd, e.sel, e.tick, e.upd);
            end
            if (frame_tick === 1'b1) ticks++;
        end
        total++;
        if (ticks != 2) begin
            bad++;
            $display("FAIL tick_count got=%0d want=2", ticks);
        end
    endtask

    task automatic test_deferred_update();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            drive(i == 10, 16'h1234, 1'b0);
            e = sb.pop_front();
            total++;
            if ({bcd_out, dig_sel, frame_tick, upd_done} !== {e.bcd, e.sel, e.tick, e.upd}) begin
                bad++;
                $display("FAIL deferred cyc=%0d got bcd=%h sel=%b tick=%b upd=%b want bcd=%h sel=%b tick=%b upd=%b",
                         i + 1, bcd_out, dig_sel, frame_tick, upd_done, e.bcd, e.sel, e.tick, e.upd);
            end
            if (i == 31) begin
                total++;
                if ({upd_done, frame_tick, bcd_out} !== {1'b1, 1'b1, 4'h4}) begin
                    bad++;
                    $display("FAIL deferred_wrap got upd=%b tick=%b bcd=%h want upd=1 tick=1 bcd=4",
                             upd_done, frame_tick, bcd_out);
                end
            end
        end
    endtask

    task automatic test_latest_wins();
        exp_t e;
        int   upds = 0;
        int   odd  = 0;
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            if (i == 5)       drive(1'b1, 16'h1111, 1'b0);
            else if (i == 20) drive(1'b1, 16'h2222, 1'b0);
            else              drive(1'b0, 16'h0000, 1'b0);
            e = sb.pop_front();
            total++;
            if ({bcd_out, dig_sel, frame_tick, upd_done} !== {e.bcd, e.sel, e.tick, e.upd}) begin
                bad++;
                $display("FAIL latest cyc=%0d got bcd=%h sel=%b tick=%b upd=%b want bcd=%h sel=%b tick=%b upd=%b",
                         i + 1, bcd_out, dig_sel, frame_tick, upd_done, e.bcd, e.sel, e.tick, e.upd);
            end
            if (upd_done === 1'b1) upds++;
            if (bcd_out !== 4'h0 && bcd_out !== 4'h2) odd++;
        end
        total++;
        if (upds != 1 || odd != 0) begin
            bad++;
            $display("FAIL latest_summary got upds=%0d odd_digits=%0d want upds=1 odd_digits=0", upds, odd);
        end
    endtask

    task automatic test_lz_blank();
        exp_t        e;
        logic [15:0] vals [3] = '{16'h0045, 16'h0000, 16'h0A05};
        int          lit_want [3] = '{12, 6, 18};
        int          lit;
        for (int v = 0; v < 3; v++) begin
            apply_reset();
            lit = 0;
            for (int i = 0; i < 64; i++) begin
                drive(i == 0, vals[v], 1'b1);
                e = sb.pop_front();
                total++;
                if ({bcd_out, dig_sel, frame_tick, upd_done} !== {e.bcd, e.sel, e.tick, e.upd}) begin
                    bad++;
                    $display("FAIL lz_%h cyc=%0d got bcd=%h sel=%b tick=%b upd=%b want bcd=%h sel=%b tick=%b upd=%b",
                             vals[v], i + 1, bcd_out, dig_sel, frame_tick, upd_done, e.bcd, e.sel, e.tick, e.upd);
                end
                if (i >= 31 && i < 63 && dig_sel !== 4'hf) lit++;
            end
            total++;
            if (lit != lit_want[v]) begin
                bad++;
                $display("FAIL lz_lit_%h got=%0d want=%0d", vals[v], lit, lit_want[v]);
            end
        end
    endtask

    task automatic test_load_on_wrap();
        exp_t e;
        int   upds = 0;
        apply_reset();
        for (int i = 0; i < 96; i++) begin
            if (i == 3)       drive(1'b1, 16'h1111, 1'b0);
            else if (i == 31) drive(1'b1, 16'h9999, 1'b0);
            else              drive(1'b0, 16'h0000, 1'b0);
            e = sb.pop_front();
            total++;
            if ({bcd_out, dig_sel, frame_tick, upd_done} !== {e.bcd, e.sel, e.tick, e.upd}) begin
                bad++;
                $display("FAIL wrapload cyc=%0d got bcd=%h sel=%b tick=%b upd=%b want bcd=%h sel=%b tick=%b upd=%b",
                         i + 1, bcd_out, dig_sel, frame_tick, upd_done, e.bcd, e.sel, e.tick, e.upd);
            end
            if (upd_done === 1'b1) upds++;
            if (i == 31 || i == 63) begin
                total++;
                if ({upd_done, bcd_out} !== {1'b1, (i == 31) ? 4'h1 : 4'h9}) begin
                    bad++;
                    $display("FAIL wrapload_frame cyc=%0d got upd=%b bcd=%h want upd=1 bcd=%h",
                             i + 1, upd_done, bcd_out, (i == 31) ? 4'h1 : 4'h9);
                end
            end
        end
        total++;
        if (upds != 2) begin
            bad++;
            $display("FAIL wrapload_upds got=%0d want=2", upds);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int   upds = 0;
        apply_reset();
        for (int i = 0; i < 53; i++) begin
            if (i == 2)       drive(1'b1, 16'h5678, 1'b0);
            else if (i == 35) drive(1'b1, 16'h4321, 1'b0);
            else              drive(1'b0, 16'h0000, 1'b0);
            e = sb.pop_front();
            total++;
            if ({bcd_out, dig_sel, frame_tick, upd_done} !== {e.bcd, e.sel, e.tick, e.upd}) begin
                bad++;
                $display("FAIL midrst_pre cyc=%0d got bcd=%h sel=%b tick=%b upd=%b want bcd=%h sel=%b tick=%b upd=%b",
                         i + 1, bcd_out, dig_sel, frame_tick, upd_done, e.bcd, e.sel, e.tick, e.upd);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bcd_out, dig_sel} !== {4'h0, 4'hf}) begin
            bad++;
            $display("FAIL midrst_async got bcd=%h sel=%b want bcd=0 sel=1111", bcd_out, dig_sel);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 16'h0000, 1'b0);
            e = sb.pop_front();
            total++;
            if ({bcd_out, dig_sel, frame_tick, upd_done} !== {e.bcd, e.sel, e.tick, e.upd}) begin
                bad++;
                $display("FAIL midrst_post cyc=%0d got bcd=%h sel=%b tick=%b upd=%b want bcd=%h sel=%b tick=%b upd=%b",
                         i + 1, bcd_out, dig_sel, frame_tick, upd_done, e.bcd, e.sel, e.tick, e.upd);
            end
            if (upd_done === 1'b1) upds++;
        end
        total++;
        if (upds != 0) begin
            bad++;
            $display("FAIL midrst_upds got=%0d want=0", upds);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data_in = '0; lz_en = 1'b0;
        model_reset();
        test_reset();
        test_deferred_update();
        test_latest_wins();
        test_lz_blank();
        test_load_on_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. It shares one BCD-to-seven-segment decoder across `DIGITS` digit positions. It steps a digit index at a programmable rate and drives the shared decoder's 4-bit BCD input together with an active-low digit-select bus. A blanking gap at the start of each slot prevents ghosting, and leading zeros can be suppressed. New display values are accepted through a load strobe into a shadow register and applied only at a frame boundary, so a frame is never torn.

## Interface
- `DIGITS`, 4: number of digit positions, 2..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot, ≥ 2.
- `BLANK_CYC`, 500: cycles at the start of each slot with all digits off, 0 ≤ `BLANK_CYC` < `SCAN_DIV`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `data_in` in 4*`DIGITS`: BCD value; `data_in[3:0]` is digit 0 (least significant).
- `load` in 1: single-cycle strobe, captures `data_in` into the shadow register.
- `lz_en` in 1: leading-zero blanking enable, level, sampled every cycle.
- `bcd_out` out 4: BCD value for the shared decoder.
- `dig_sel` out `DIGITS`: digit enables, active-low; bit i drives digit i.
- `frame_tick` out 1: one-cycle pulse at each frame wrap.
- `upd_done` out 1: one-cycle pulse when the shadow register is transferred to the display register.

## Operation
- **Prescaler `cnt`**
  - Counts 0..`SCAN_DIV`-1 and wraps to 0.
  - The wrap edge (`cnt`==`SCAN_DIV`-1) advances slot index `idx`, which counts 0..`DIGITS`-1 and wraps to 0.
- **Frame wrap edge:** the edge where `cnt`==`SCAN_DIV`-1 and `idx`==`DIGITS`-1.
- **Registers**
  - `disp`: display register, 4*`DIGITS` bits.
  - `pend`: shadow register.
  - `pend_v`: shadow-valid flag.
- **Load**
  - `load`=1 on an edge writes `pend`<=`data_in` and sets `pend_v`<=1.
  - Loads arriving before the frame wrap overwrite `pend`; the latest value wins.
- **Transfer**
  - At the frame wrap edge, if `pend_v`=1: `disp`<=`pend` and `upd_done` is asserted for the next cycle.
  - `pend_v` clears unless `load`=1 on the same edge.
  - A load on the frame wrap edge: the transfer uses the old `pend`; the new data becomes `pend` with `pend_v`=1 and is applied at the following frame wrap.
- **`frame_tick`:** asserted for the cycle following every frame wrap edge, independent of `pend_v`.
- **Slot i (`idx`==i)**
  - `bcd_out` = `disp[4i+3:4i]`.
  - `dig_sel` = all ones while `cnt` < `BLANK_CYC`.
  - Otherwise `dig_sel` = ~(1<<i), unless digit i is blanked, in which case it stays all ones.
- **Leading-zero blanking**
  - Digit i (i ≥ 1) is blanked when `lz_en`=1 and `disp` digits i..`DIGITS`-1 are all 4'h0.
  - Digit 0 is never blanked.
- **Codes 10–15:** passed through unchanged on `bcd_out`; the decoder's default branch handles them. These codes count as nonzero for blanking.

## Timing
- **Reset values (asynchronous, take effect immediately on `rst`)**
  - `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pend_v`=0.
  - `bcd_out`=4'h0, `dig_sel`=all ones, `frame_tick`=0, `upd_done`=0.
- **Reset behaviour**
  - Reset mid-frame drops any pending value.
  - After release, scanning restarts at slot 0 with `cnt`=0.
- **Output registers:** all outputs are registered and aligned with the current `cnt`/`idx`.
  - With `BLANK_CYC`=0, the first cycle of slot i already drives ~(1<<i).
- **Output change points:** `bcd_out` changes only at slot wrap edges; `dig_sel` changes only at slot wraps and at the `cnt`==`BLANK_CYC` edge.
- **Latency**
  - `load` to visible value: from 1 cycle (load one edge before the frame wrap) to `DIGITS`*`SCAN_DIV` cycles.
  - `upd_done` and `frame_tick` coincide with the first cycle of slot 0 of the new frame.
- **Frame period:** `DIGITS`*`SCAN_DIV` cycles. The first `frame_tick` after reset comes `DIGITS`*`SCAN_DIV` cycles after release.

## Test plan
All scenarios use `DIGITS`=4, `SCAN_DIV`=8, `BLANK_CYC`=2.

1. **Reset and scan.** Release `rst` -> `dig_sel`=4'b1111 for 2 cycles, then 4'b1110 for 6 cycles, then 1111×2, 1101×6, 1111×2, 1011×6, 1111×2, 0111×6, repeating. `frame_tick` pulses at cycle 32 after release. `bcd_out`=0 throughout.
2. **Deferred update.** `load` with `data_in`=16'h1234 at cycle 10 -> `bcd_out` stays 0 until cycle 32. At cycle 32 `upd_done`=1 and `frame_tick`=1. The next frame shows slot0=4, slot1=3, slot2=2, slot3=1.
3. **Latest load wins.** `load` with 16'h1111 at cycle 5, then 16'h2222 at cycle 20 -> only 2 is ever displayed. Exactly one `upd_done` pulse, at cycle 32.
4. **Leading-zero blanking.**
   - `disp`=16'h0045, `lz_en`=1 -> slots 2 and 3 hold `dig_sel`=4'b1111 for the full slot; slots 0 and 1 drive normally.
   - `disp`=16'h0000 -> only digit 0 is lit, with `bcd_out`=0.
   - `disp`=16'h0A05 -> digits 0–2 lit, digit 3 blanked.
5. **Load on the frame wrap edge.** `pend`=16'h1111 is valid; `load` of 16'h9999 on the frame wrap edge -> the frame shows 1111 with `upd_done`. 9999 is applied at the next wrap with a second `upd_done`.
6. **Mid-frame reset.** Assert `rst` in slot 2 at `cnt`=5 with `disp`=16'h5678 and a pending 16'h4321 -> `dig_sel`=1111 and `bcd_out`=0 without waiting for a clock edge. After release, 0000 is displayed and no `upd_done` occurs.
